serial_axi_master: RTL and testbench
====================================

# serial_axi_master

AXI4-lite initiator that turns single-beat command requests into AXI4-lite write or read transactions and returns the completion to the requester. It sits between a local controller (test sequencer or soft-processor bridge) and the serial IP's AXI4-lite slave port. It exercises the register map: data 0x0, status 0x4, control 0x8, brd 0xC. Exactly one transaction is in flight at a time, and each one reports its completion latency.

## Interface
Parameters:
- C_M_AXI_ADDR_WIDTH, 4, width of the AXI address buses and of cmd_addr.
- LAT_WIDTH, 8, width of the saturating latency counter.

Ports:
- M_AXI_ACLK  in  1  single clock; everything is rising-edge.
- M_AXI_ARESETN  in  1  reset; asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- rsp_valid  out  1  completion available.
- rsp_ready  in  1  completion consumed.
- rsp_write  out  1  echoes cmd_write.
- rsp_data  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- rsp_latency  out  LAT_WIDTH  cycles from accept to bus response handshake, saturating.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-lite master directions and widths. AWPROT and ARPROT are tied to 3'b000.

## Operation
State machine: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.

- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid: register addr, wdata and wstrb, clear the latency counter, and go to WR_ADDR_DATA (write) or RD_ADDR (read).
- **WR_ADDR_DATA**
  - AWVALID and WVALID are asserted together.
  - Each valid drops independently in the cycle after its own READY is sampled high. aw_done and w_done flags record completion.
  - Go to WR_RESP when both handshakes are done. This includes both completing in the same cycle, or one completing in the same cycle the other's flag is already set.
- **WR_RESP**
  - BREADY = 1.
  - On BVALID: capture BRESP, set rsp_data = 0, go to DONE.
- **RD_ADDR**
  - ARVALID = 1 until ARREADY is sampled high, then go to RD_DATA.
- **RD_DATA**
  - RREADY = 1.
  - On RVALID: capture RDATA and RRESP, go to DONE.
- **DONE**
  - rsp_valid = 1, and all rsp_* outputs are stable.
  - On rsp_ready, go to IDLE.
- **Latency counter**
  - Increments every cycle in the four bus states and saturates at all-ones.
  - Its value is frozen into rsp_latency at the cycle of the B or R handshake.
- **Valid/address stability**
  - AXI valids never depend combinationally on READY.
  - Address, data and strobes are held stable while the corresponding valid is high.
- **Command acceptance**
  - cmd_ready is low outside IDLE; commands presented then are ignored, not queued.
  - cmd_addr is passed through unmodified, including its low bits; no alignment check is made.

## Timing
- **Reset:** asynchronous assertion forces state to IDLE immediately and clears all outputs:
  - all AXI valids and readies = 0;
  - AWADDR, ARADDR, WDATA, WSTRB = 0;
  - rsp_valid = 0, rsp_data = 0, rsp_resp = 0, rsp_latency = 0, rsp_write = 0;
  - cmd_ready = 0 while reset is asserted, and 1 on the first clock after release.
- **Reset mid-transaction:** the transaction is abandoned with no response, and the internal aw_done/w_done flags are cleared.
- **Valid/ready timing:**
  - AWVALID, WVALID or ARVALID rise in the cycle after command accept.
  - BREADY or RREADY rise in the cycle after the last address/data handshake.
- **Minimum write latency** (slave gives all readies at first opportunity): accept at T, AW/W valids at T+1, readies at T+2, BREADY at T+3.
  - When BVALID is present at T+3, rsp_valid rises at T+4 and rsp_latency = 3.
- **Minimum read latency:** accept at T, ARVALID at T+1, ARREADY at T+2, RREADY at T+3.
  - When RVALID is present at T+3, rsp_valid rises at T+4.
- **Back-to-back commands:** a new command is accepted no earlier than the cycle after the rsp_valid & rsp_ready handshake.
- **Latency saturation:** a stalled slave saturates rsp_latency at 2^LAT_WIDTH-1. There is no timeout; the FSM waits indefinitely.

## Test plan
1. **Write then read control:** write 0x8 with 0x0000_0010 and wstrb 0xF, then read 0x8.
   - Write: rsp_resp = 0, rsp_write = 1, rsp_data = 0.
   - Read: rsp_data = 0x0000_0010, rsp_resp = 0.
2. **Skewed handshakes:** model slave asserts WREADY 3 cycles before AWREADY.
   - WVALID drops after WREADY while AWVALID stays high.
   - BREADY is asserted only after AWREADY; exactly one write is observed.
   - The test is repeated with AWREADY and WREADY in the same cycle.
3. **Partial strobe:** write brd 0xC with 0xAABBCCDD and wstrb 0x3 after brd = 0. Reading 0xC then returns 0x0000CCDD.
4. **Response backpressure:** hold rsp_ready = 0 for 10 cycles after a read.
   - rsp_valid, rsp_data and rsp_latency stay constant.
   - cmd_ready stays 0, and a command pulsed during this window is ignored.
5. **Slow slave:** delay RVALID by 300 cycles. rsp_latency = 255 (saturated), and rsp_data is correct.
6. **Reset mid-write:** assert M_AXI_ARESETN = 0 while AWVALID = 1.
   - AWVALID and WVALID drop without waiting for a clock.
   - rsp_valid never rises.
   - After release, cmd_ready = 1 and a following read of 0x8 completes normally.

Source files
------------

// File: rtl/serial_axi_master_if.sv
// serial_axi_master_if: AXI4-lite bus between the serial initiator
// and the serial IP register slave.
interface serial_axi_master_if #(
  parameter int C_M_AXI_ADDR_WIDTH = 4
);
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/serial_axi_master.sv
// serial_axi_master: single-outstanding AXI4-lite initiator that turns
// command requests into bus transactions and reports their latency.
module serial_axi_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4,
  parameter int LAT_WIDTH          = 8
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [31:0]                   rsp_data,
  output logic [1:0]                    rsp_resp,
  output logic [LAT_WIDTH-1:0]          rsp_latency,
  serial_axi_master_if.master           m_axi
);
  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } state_t;

  state_t state, state_d;
  logic   aw_done, aw_done_d;
  logic   w_done, w_done_d;
  logic   awvalid, wvalid, bready;
  logic   arvalid, rready;
  logic   accept, bus_busy;
  logic   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [LAT_WIDTH-1:0] lat, lat_inc;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  assign accept = cmd_valid & cmd_ready;
  assign aw_hs  = awvalid & m_axi.M_AXI_AWREADY;
  assign w_hs   = wvalid & m_axi.M_AXI_WREADY;
  assign b_hs   = bready & m_axi.M_AXI_BVALID;
  assign ar_hs  = arvalid & m_axi.M_AXI_ARREADY;
  assign r_hs   = rready & m_axi.M_AXI_RVALID;

  assign bus_busy = state inside
    {WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA};
  assign lat_inc = (&lat) ? lat : lat + 1'b1;

  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d   = cmd_write ? WR_ADDR_DATA : RD_ADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done | aw_hs;
        w_done_d  = w_done | w_hs;
        if (aw_done_d & w_done_d) state_d = WR_RESP;
      end
      WR_RESP: if (b_hs) state_d = DONE;
      RD_ADDR: if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state     <= IDLE;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      cmd_ready <= 1'b0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_d;
      aw_done   <= aw_done_d;
      w_done    <= w_done_d;
      cmd_ready <= state_d == IDLE;
      awvalid   <= (state_d == WR_ADDR_DATA) & ~aw_done_d;
      wvalid    <= (state_d == WR_ADDR_DATA) & ~w_done_d;
      bready    <= state_d == WR_RESP;
      arvalid   <= state_d == RD_ADDR;
      rready    <= state_d == RD_DATA;
      rsp_valid <= state_d == DONE;
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      awaddr      <= '0;
      araddr      <= '0;
      wdata       <= '0;
      wstrb       <= '0;
      lat         <= '0;
      rsp_write   <= 1'b0;
      rsp_data    <= '0;
      rsp_resp    <= '0;
      rsp_latency <= '0;
    end else begin
      if (accept & cmd_write) begin
        awaddr <= cmd_addr;
        wdata  <= cmd_wdata;
        wstrb  <= cmd_wstrb;
      end
      if (accept & ~cmd_write) araddr <= cmd_addr;
      if (accept) begin
        rsp_write <= cmd_write;
        lat       <= '0;
      end else if (bus_busy) begin
        lat <= lat_inc;
      end
      if (b_hs) begin
        rsp_resp    <= m_axi.M_AXI_BRESP;
        rsp_data    <= '0;
        rsp_latency <= lat_inc;
      end
      if (r_hs) begin
        rsp_resp    <= m_axi.M_AXI_RRESP;
        rsp_data    <= m_axi.M_AXI_RDATA;
        rsp_latency <= lat_inc;
      end
    end
  end

  assign m_axi.M_AXI_AWADDR  = awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid;
  assign m_axi.M_AXI_WDATA   = wdata;
  assign m_axi.M_AXI_WSTRB   = wstrb;
  assign m_axi.M_AXI_WVALID  = wvalid;
  assign m_axi.M_AXI_BREADY  = bready;
  assign m_axi.M_AXI_ARADDR  = araddr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid;
  assign m_axi.M_AXI_RREADY  = rready;
endmodule

// File: tb/tb_serial_axi_master.sv
// tb_serial_axi_master: directed bench with a delay-programmable
// register slave and a transaction-level response model.
module tb_serial_axi_master;
  localparam int AW = 4;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0] cmd_wstrb = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic rsp_write;
  logic [31:0] rsp_data;
  logic [1:0] rsp_resp;
  logic [LW-1:0] rsp_latency;

  serial_axi_master_if #(.C_M_AXI_ADDR_WIDTH(AW)) bus();

  serial_axi_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .LAT_WIDTH(LW)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_data(rsp_data),
    .rsp_resp(rsp_resp),
    .rsp_latency(rsp_latency),
    .m_axi(bus)
  );

  always #5 clk = ~clk;

  // Slave with per-channel ready/valid delays
  int aw_dly = 0, w_dly = 0, b_dly = 0;
  int ar_dly = 0, r_dly = 0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic awready, wready, bvalid;
  logic arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic aw_got, w_got, ar_got;
  logic [AW-1:0] aw_addr_s, ar_addr_s;
  logic [31:0] w_data_s;
  logic [3:0] w_strb_s;
  logic [31:0] mem [4] = '{default: 32'h0};

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_now, w_now, ar_now;
  logic [AW-1:0] wa, ra;
  logic [31:0] wdat, wmask;
  logic [3:0] wstb;

  assign aw_hs = bus.M_AXI_AWVALID && awready;
  assign w_hs  = bus.M_AXI_WVALID && wready;
  assign b_hs  = bvalid && bus.M_AXI_BREADY;
  assign ar_hs = bus.M_AXI_ARVALID && arready;
  assign r_hs  = rvalid && bus.M_AXI_RREADY;
  assign aw_now = aw_got || aw_hs;
  assign w_now  = w_got || w_hs;
  assign ar_now = ar_got || ar_hs;
  assign wa   = aw_hs ? bus.M_AXI_AWADDR : aw_addr_s;
  assign wdat = w_hs ? bus.M_AXI_WDATA : w_data_s;
  assign wstb = w_hs ? bus.M_AXI_WSTRB : w_strb_s;
  assign ra   = ar_hs ? bus.M_AXI_ARADDR : ar_addr_s;
  assign wmask = {{8{wstb[3]}}, {8{wstb[2]}},
                  {8{wstb[1]}}, {8{wstb[0]}}};

  assign bus.M_AXI_AWREADY = awready;
  assign bus.M_AXI_WREADY  = wready;
  assign bus.M_AXI_BVALID  = bvalid;
  assign bus.M_AXI_BRESP   = bresp;
  assign bus.M_AXI_ARREADY = arready;
  assign bus.M_AXI_RVALID  = rvalid;
  assign bus.M_AXI_RDATA   = rdata;
  assign bus.M_AXI_RRESP   = rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 0; wready <= 0; bvalid <= 0;
      arready <= 0; rvalid <= 0;
      bresp <= 0; rresp <= 0; rdata <= 0;
      aw_got <= 0; w_got <= 0; ar_got <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
      ar_cnt <= 0; r_cnt <= 0;
      aw_addr_s <= 0; ar_addr_s <= 0;
      w_data_s <= 0; w_strb_s <= 0;
    end else begin
      if (awready) awready <= 0;
      else if (bus.M_AXI_AWVALID && !aw_got) begin
        if (aw_cnt == aw_dly) begin
          awready <= 1; aw_cnt <= 0;
        end else aw_cnt <= aw_cnt + 1;
      end
      if (aw_hs) begin
        aw_got <= 1; aw_addr_s <= bus.M_AXI_AWADDR;
      end
      if (wready) wready <= 0;
      else if (bus.M_AXI_WVALID && !w_got) begin
        if (w_cnt == w_dly) begin
          wready <= 1; w_cnt <= 0;
        end else w_cnt <= w_cnt + 1;
      end
      if (w_hs) begin
        w_got <= 1;
        w_data_s <= bus.M_AXI_WDATA;
        w_strb_s <= bus.M_AXI_WSTRB;
      end
      if (bvalid) begin
        if (bus.M_AXI_BREADY) bvalid <= 0;
      end else if (aw_now && w_now) begin
        if (b_cnt == b_dly) begin
          bvalid <= 1; b_cnt <= 0;
          aw_got <= 0; w_got <= 0;
          if (wa[1:0] == 2'b00) begin
            bresp <= 2'b00;
            mem[wa[3:2]] <= (mem[wa[3:2]] & ~wmask)
                          | (wdat & wmask);
          end else bresp <= 2'b10;
        end else b_cnt <= b_cnt + 1;
      end
      if (arready) arready <= 0;
      else if (bus.M_AXI_ARVALID && !ar_got) begin
        if (ar_cnt == ar_dly) begin
          arready <= 1; ar_cnt <= 0;
        end else ar_cnt <= ar_cnt + 1;
      end
      if (ar_hs) begin
        ar_got <= 1; ar_addr_s <= bus.M_AXI_ARADDR;
      end
      if (rvalid) begin
        if (bus.M_AXI_RREADY) rvalid <= 0;
      end else if (ar_now) begin
        if (r_cnt == r_dly) begin
          rvalid <= 1; r_cnt <= 0; ar_got <= 0;
          if (ra[1:0] == 2'b00) begin
            rdata <= mem[ra[3:2]]; rresp <= 2'b00;
          end else begin
            rdata <= 32'hDEADBEEF; rresp <= 2'b10;
          end
        end else r_cnt <= r_cnt + 1;
      end
    end
  end

  int aw_tot = 0, w_tot = 0, b_tot = 0;
  int ar_tot = 0, r_tot = 0;
  always @(posedge clk) begin
    if (aw_hs) aw_tot <= aw_tot + 1;
    if (w_hs)  w_tot <= w_tot + 1;
    if (b_hs)  b_tot <= b_tot + 1;
    if (ar_hs) ar_tot <= ar_tot + 1;
    if (r_hs)  r_tot <= r_tot + 1;
  end

  // Transaction-level model: register file plus expected response
  logic [31:0] mdl [4];
  logic exp_pending = 1'b0;
  logic exp_write;
  logic [31:0] exp_data;
  logic [1:0] exp_resp;
  logic [LW-1:0] exp_lat;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic monitor();
    logic pv_aw = 0, pr_aw = 0, pv_ar = 0, pr_ar = 0;
    logic p_whs = 0;
    logic [AW-1:0] p_awa = 0, p_ara = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rsp_valid) begin
          check("rsp_expected", exp_pending, 1);
          check("rsp_write", rsp_write, exp_write);
          check("rsp_data", rsp_data, exp_data);
          check("rsp_resp", rsp_resp, exp_resp);
          check("rsp_latency", rsp_latency, exp_lat);
          check("cmd_ready_busy", cmd_ready, 0);
        end
        if (pv_aw && !pr_aw) begin
          check("awvalid_hold", bus.M_AXI_AWVALID, 1);
          check("awaddr_hold", bus.M_AXI_AWADDR, p_awa);
        end
        if (pv_ar && !pr_ar) begin
          check("arvalid_hold", bus.M_AXI_ARVALID, 1);
          check("araddr_hold", bus.M_AXI_ARADDR, p_ara);
        end
        if (p_whs) check("wvalid_drop", bus.M_AXI_WVALID, 0);
        if (bus.M_AXI_BREADY) begin
          check("bready_after_aw", aw_tot, b_tot + 1);
          check("bready_after_w", w_tot, b_tot + 1);
        end
      end
      pv_aw = bus.M_AXI_AWVALID; pr_aw = awready;
      pv_ar = bus.M_AXI_ARVALID; pr_ar = arready;
      p_awa = bus.M_AXI_AWADDR; p_ara = bus.M_AXI_ARADDR;
      p_whs = bus.M_AXI_WVALID && wready;
    end
  endtask

  task automatic do_cmd(
    input logic wr, input logic [AW-1:0] addr,
    input logic [31:0] data, input logic [3:0] strb,
    input int awd, input int wd, input int bd,
    input int ard, input int rd, input int bp,
    output logic [31:0] got_data,
    output logic [1:0] got_resp,
    output logic [LW-1:0] got_lat);
    int raw, k, awb, wb, bb, arb, rb;
    logic [31:0] mask;
    aw_dly = awd; w_dly = wd; b_dly = bd;
    ar_dly = ard; r_dly = rd;
    raw = wr ? 3 + ((awd > wd) ? awd : wd) + bd
             : 3 + ard + rd;
    exp_write = wr;
    exp_resp = (addr[1:0] != 2'b00) ? 2'b10 : 2'b00;
    exp_lat = (raw > 255) ? 8'hFF : raw[7:0];
    if (wr) exp_data = 32'h0;
    else if (addr[1:0] != 2'b00) exp_data = 32'hDEADBEEF;
    else exp_data = mdl[addr[3:2]];
    awb = aw_tot; wb = w_tot; bb = b_tot;
    arb = ar_tot; rb = r_tot;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr;
    cmd_wdata = data; cmd_wstrb = strb;
    rsp_ready = (bp == 0);
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk); k++;
    end
    check("cmd_accept", cmd_ready, 1);
    exp_pending = 1;
    @(negedge clk);
    cmd_valid = 0;
    k = 1;
    while (!rsp_valid && k < 400) begin
      @(negedge clk); k++;
    end
    check("rsp_rise_cycle", k, raw + 1);
    got_data = rsp_data; got_resp = rsp_resp;
    got_lat = rsp_latency;
    if (bp > 0) begin
      for (int i = 0; i < bp; i++) begin
        if (i == 3) begin
          cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h0;
          cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
        end
        if (i == 4) cmd_valid = 0;
        @(negedge clk);
      end
      rsp_ready = 1;
    end
    @(posedge clk);
    exp_pending = 0;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_dropped", rsp_valid, 0);
    check("cmd_ready_idle", cmd_ready, 1);
    check("aw_count", aw_tot - awb, wr ? 1 : 0);
    check("w_count", w_tot - wb, wr ? 1 : 0);
    check("b_count", b_tot - bb, wr ? 1 : 0);
    check("ar_count", ar_tot - arb, wr ? 0 : 1);
    check("r_count", r_tot - rb, wr ? 0 : 1);
    if (wr && addr[1:0] == 2'b00) begin
      mask = {{8{strb[3]}}, {8{strb[2]}},
              {8{strb[1]}}, {8{strb[0]}}};
      mdl[addr[3:2]] = (mdl[addr[3:2]] & ~mask)
                     | (data & mask);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0] r;
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
    fork
      monitor();
    join_none

    repeat (2) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", bus.M_AXI_AWVALID, 0);
    check("rst_wvalid", bus.M_AXI_WVALID, 0);
    check("rst_arvalid", bus.M_AXI_ARVALID, 0);
    check("rst_bready", bus.M_AXI_BREADY, 0);
    check("rst_rready", bus.M_AXI_RREADY, 0);
    check("rst_awaddr", bus.M_AXI_AWADDR, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_lat", rsp_latency, 0);
    rst_n = 1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);

    do_cmd(1, 4'h8, 32'h10, 4'hF, 0, 0, 0, 0, 0, 0, d, r, l);
    check("t1_wr_lat", l, 3);
    check("t1_wr_resp", r, 0);
    check("t1_wr_data", d, 0);
    do_cmd(0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, d, r, l);
    check("t1_rd_data", d, 32'h10);
    check("t1_rd_lat", l, 3);

    do_cmd(1, 4'h0, 32'h11111111, 4'hF,
           3, 0, 0, 0, 0, 0, d, r, l);
    check("t2_skew_lat", l, 6);
    do_cmd(1, 4'h0, 32'h22222222, 4'hF,
           2, 2, 0, 0, 0, 0, d, r, l);
    check("t2_same_lat", l, 5);
    do_cmd(1, 4'h4, 32'h33, 4'hF, 0, 3, 2, 0, 0, 0, d, r, l);
    check("t2_wskew_lat", l, 8);
    do_cmd(0, 4'h0, 0, 0, 0, 0, 0, 1, 1, 0, d, r, l);
    check("t2_rd_data", d, 32'h22222222);
    check("t2_rd_lat", l, 5);

    do_cmd(1, 4'hC, 32'hAABBCCDD, 4'h3,
           0, 0, 0, 0, 0, 0, d, r, l);
    do_cmd(0, 4'hC, 0, 0, 0, 0, 0, 0, 0, 0, d, r, l);
    check("t3_strobe_data", d, 32'h0000CCDD);

    do_cmd(0, 4'h4, 0, 0, 0, 0, 0, 0, 0, 10, d, r, l);
    check("t4_bp_data", d, 32'h33);

    do_cmd(0, 4'h8, 0, 0, 0, 0, 0, 0, 300, 0, d, r, l);
    check("t5_sat_lat", l, 255);
    check("t5_sat_data", d, 32'h10);

    do_cmd(1, 4'h9, 32'h55, 4'hF, 0, 0, 0, 0, 0, 0, d, r, l);
    check("t7_wr_slverr", r, 2);
    do_cmd(0, 4'h5, 0, 0, 0, 0, 0, 0, 0, 0, d, r, l);
    check("t7_rd_slverr", r, 2);
    check("t7_rd_data", d, 32'hDEADBEEF);

    aw_dly = 5; w_dly = 5;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'h8;
    cmd_wdata = 32'hFFFFFFFF; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    check("t6_awvalid_pre", bus.M_AXI_AWVALID, 1);
    #2 rst_n = 0;
    #1;
    check("t6_awvalid_async", bus.M_AXI_AWVALID, 0);
    check("t6_wvalid_async", bus.M_AXI_WVALID, 0);
    check("t6_cmd_ready_rst", cmd_ready, 0);
    check("t6_rsp_valid_rst", rsp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("t6_cmd_ready_post", cmd_ready, 1);
    do_cmd(0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0, d, r, l);
    check("t6_rd_data", d, 32'h10);
    check("t6_rd_lat", l, 3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
